// File: rtl/ediv_pkg.sv
// ediv_pkg -- shared definitions for the ediv restoring divider.
//   state_t            : controller states (IDLE, RUN, DONE)
//   DEF_DIVIDEND_W     : default dividend/quotient width
//   DEF_DIVISOR_W      : default divisor/remainder width
//   ITERS_R2/ITERS_R4  : RUN-cycle counts at default width per radix
//   run_cycles()       : RUN-cycle count for an arbitrary dividend width,
//                        selected by the EDIV_RADIX4_EN build macro
package ediv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DIVIDEND_W = 16;
  localparam int DEF_DIVISOR_W  = 8;

  localparam int ITERS_R2 = DEF_DIVIDEND_W;
  localparam int ITERS_R4 = DEF_DIVIDEND_W / 2;

  function automatic int run_cycles(input int dividend_w);
`ifdef EDIV_RADIX4_EN
    return dividend_w / 2;
`else
    return dividend_w;
`endif
  endfunction

endpackage

// File: rtl/ediv_step.sv
// ediv_step -- one combinational shift-compare-subtract step of a restoring
// divider.
//   rem_in  : current partial remainder (always < divisor)
//   bit_in  : next dividend bit shifted into the partial remainder
//   divisor : denominator
//   rem_out : partial remainder after the step (always < divisor)
//   qbit    : resulting quotient bit (1 = subtraction kept)
module ediv_step #(
  parameter int DIVISOR_W = 8
) (
  input  logic [DIVISOR_W-1:0] rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] rem_out,
  output logic                 qbit
);

  logic [DIVISOR_W:0]   shifted;
  logic [DIVISOR_W-1:0] diff_lo;
  logic                 borrow;

  assign shifted = {rem_in, bit_in};

  // The subtraction only needs the low DIVISOR_W bits: when the shifted MSB
  // is set the partial remainder already exceeds any divisor, and the true
  // difference is below the divisor, so its low bits are exact.
  assign {borrow, diff_lo} = {1'b0, shifted[DIVISOR_W-1:0]} - {1'b0, divisor};

  assign qbit    = shifted[DIVISOR_W] | ~borrow;
  assign rem_out = qbit ? diff_lo : shifted[DIVISOR_W-1:0];

endmodule

// File: rtl/ediv.sv
// ediv -- iterative unsigned restoring divider.
//   clock     : single clock, rising edge
//   reset_n   : asynchronous active-low reset
//   start     : request a division (sampled only in IDLE)
//   dividend  : numerator, captured on an accepted start
//   divisor   : denominator, captured on an accepted start
//   quotient  : registered quotient (all ones on divide by zero)
//   remainder : registered remainder (dividend low bits on divide by zero)
//   busy      : high in RUN and DONE
//   done      : one-cycle pulse when results are valid
//   dbz       : divide-by-zero flag, valid with done
// Build option: define EDIV_RADIX4_EN to retire two quotient bits per cycle
// (two cascaded steps, DIVIDEND_W/2 RUN cycles; DIVIDEND_W must be even).
module ediv
  import ediv_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  dbz
);

  localparam int ITERS = run_cycles(DIVIDEND_W);
  localparam int CNT_W = $clog2(ITERS + 1);

  state_t state, state_nxt;
  logic [CNT_W-1:0]      cnt;

  // work holds unconsumed dividend bits at the top and collects quotient
  // bits at the bottom; after the last iteration it is the quotient.
  logic [DIVIDEND_W-1:0] work, work_nxt;
  logic [DIVISOR_W-1:0]  prem, prem_nxt;
  logic [DIVISOR_W-1:0]  dvsr;

  logic accept, zero_div, last;

  assign accept   = (state == IDLE) && start;
  assign zero_div = (divisor == '0);
  assign last     = (cnt == CNT_W'(ITERS - 1));

`ifdef EDIV_RADIX4_EN
  logic [DIVISOR_W-1:0] prem_mid;
  logic                 q_hi, q_lo;

  ediv_step #(.DIVISOR_W(DIVISOR_W)) u_step_hi (
    .rem_in  (prem),
    .bit_in  (work[DIVIDEND_W-1]),
    .divisor (dvsr),
    .rem_out (prem_mid),
    .qbit    (q_hi)
  );

  ediv_step #(.DIVISOR_W(DIVISOR_W)) u_step_lo (
    .rem_in  (prem_mid),
    .bit_in  (work[DIVIDEND_W-2]),
    .divisor (dvsr),
    .rem_out (prem_nxt),
    .qbit    (q_lo)
  );

  assign work_nxt = {work[DIVIDEND_W-3:0], q_hi, q_lo};
`else
  logic q_bit;

  ediv_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .rem_in  (prem),
    .bit_in  (work[DIVIDEND_W-1]),
    .divisor (dvsr),
    .rem_out (prem_nxt),
    .qbit    (q_bit)
  );

  assign work_nxt = {work[DIVIDEND_W-2:0], q_bit};
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = zero_div ? DONE : RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and result registers: cleared immediately by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= '0;
        dbz <= zero_div;
        if (zero_div) begin
          quotient  <= '1;
          remainder <= dividend[DIVISOR_W-1:0];
        end
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        if (last) begin
          quotient  <= work_nxt;
          remainder <= prem_nxt;
        end
      end
    end
  end

  // Working datapath: always reloaded on an accepted start, so no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      work <= dividend;
      prem <= '0;
      dvsr <= divisor;
    end else if (state == RUN) begin
      work <= work_nxt;
      prem <= prem_nxt;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_ediv.sv
module tb_ediv;

`ifdef EDIV_RADIX4_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 17;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        busy, done, dbz;

  int checks = 0;
  int failures = 0;

  ediv dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention.
  task automatic model(input logic [15:0] a, input logic [7:0] b,
                       output logic [15:0] q, output logic [7:0] r, output logic z);
    if (b == 8'd0) begin
      q = 16'hFFFF;
      r = a[7:0];
      z = 1'b1;
    end else begin
      int unsigned qi, ri;
      qi = int'(a) / int'(b);
      ri = int'(a) % int'(b);
      q = qi[15:0];
      r = ri[7:0];
      z = 1'b0;
    end
  endtask

  task automatic run_div(input logic [15:0] a, input logic [7:0] b, input string tag);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    int          lat;
    bit          seen;
    model(a, b, eq, er, ez);
    @(negedge clock);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    seen = 1'b0;
    lat  = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clock);
      if (k == 0) chk($sformatf("%s_busy", tag), busy, 1);
      if (done) begin
        seen = 1'b1;
        lat  = k + 1;
      end
    end
    chk($sformatf("%s_lat", tag), lat, ez ? 1 : LAT);
    chk($sformatf("%s_q", tag), quotient, eq);
    chk($sformatf("%s_r", tag), remainder, er);
    chk($sformatf("%s_dbz", tag), dbz, ez);
    @(negedge clock);
    chk($sformatf("%s_pulse", tag), done, 0);
    chk($sformatf("%s_idle", tag), busy, 0);
    chk($sformatf("%s_hold", tag), quotient, eq);
  endtask

  initial begin
    int ndone;
    int first;
    logic [15:0] ra;
    logic [7:0]  rb;

    repeat (3) @(negedge clock);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", dbz, 0);
    reset_n = 1'b1;

    run_div(16'd1000, 8'd7, "d1000_7");
    run_div(16'hFFFF, 8'hFF, "ffff_ff");
    run_div(16'd5, 8'd9, "d5_9");
    run_div(16'h1234, 8'd0, "dbz");
    run_div(16'd1000, 8'd7, "dbz_clear");
    run_div(16'd0, 8'd1, "zero_1");
    run_div(16'hFFFF, 8'd1, "ffff_1");
    run_div(16'd0, 8'd0, "zero_0");

    // Start re-pulsed during RUN and during DONE must be ignored.
    @(negedge clock);
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    ndone = 0;
    first = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) begin
        ndone++;
        if (first == 0) first = k + 1;
      end
      if (k == 2 || k == LAT - 1) begin
        start    = 1'b1;
        dividend = 16'($urandom);
        divisor  = 8'($urandom_range(1, 255));
      end
    end
    chk("repulse_ndone", ndone, 1);
    chk("repulse_lat", first, LAT);
    chk("repulse_q", quotient, 142);
    chk("repulse_r", remainder, 6);
    chk("repulse_dbz", dbz, 0);
    chk("repulse_busy", busy, 0);

    // Reset in the middle of a run.
    @(negedge clock);
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midrst_q", quotient, 0);
    chk("midrst_r", remainder, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_dbz", dbz, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (done) ndone++;
    end
    chk("midrst_nodone", ndone, 0);
    run_div(16'd200, 8'd3, "d200_3");

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run_div(ra, rb, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ediv.md
EDIV -- requirements
Module: ediv

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 16, meaning dividend and quotient width.
REQ-002 SHALL have parameter DIVISOR_W, default 8, meaning divisor and remainder width.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request a division; sampled only in IDLE.
REQ-006 SHALL have port dividend, input, DIVIDEND_W, numerator; captured when start is accepted.
REQ-007 SHALL have port divisor, input, DIVISOR_W, denominator; captured when start is accepted.
REQ-008 SHALL have port quotient, output, DIVIDEND_W, registered result.
REQ-009 SHALL have port remainder, output, DIVISOR_W, registered result.
REQ-010 SHALL have port busy, output, 1, high in RUN and DONE.
REQ-011 SHALL have port done, output, 1, one-cycle pulse marking valid results.
REQ-012 SHALL have port dbz, output, 1, divide-by-zero flag, valid with done.

Function
REQ-013 SHALL implement unsigned restoring division: dividend = quotient*divisor + remainder, remainder < divisor.
REQ-014 SHALL use FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after the last iteration; DONE->IDLE unconditionally after one cycle.
REQ-015 SHALL, in RUN, shift one dividend bit into a DIVISOR_W+1-bit partial remainder per cycle, subtract divisor, keep the difference and set the quotient bit to 1 when non-negative, otherwise restore and set 0.
REQ-016 SHALL, in radix-2 mode, spend exactly DIVIDEND_W cycles in RUN; done rises DIVIDEND_W+1 clocks after the accepting edge (17 at defaults).
REQ-017 SHALL ignore start while busy=1, including in DONE; inputs may change freely while busy.
REQ-018 SHALL, on a zero divisor, skip RUN (IDLE->DONE), set quotient all-ones, remainder=dividend[DIVISOR_W-1:0], dbz=1; done rises 1 clock after the accepting edge.
REQ-019 SHALL hold quotient, remainder and dbz stable from done until the next accepted start; dbz is cleared on the next accepted start.
REQ-020 SHALL assert done for exactly one cycle per accepted start.

Reset
REQ-021 SHALL, on reset_n low, immediately force state IDLE, quotient=0, remainder=0, busy=0, done=0, dbz=0, iteration counter=0.
REQ-022 SHALL abandon any division in progress on reset without producing done; first start after reset release is accepted normally.

Configuration
REQ-023 SHALL compile radix-4 iteration when macro EDIV_RADIX4_EN is defined: two cascaded restoring steps per cycle, DIVIDEND_W/2 RUN cycles, done 9 clocks after the accepting edge at defaults.
REQ-024 SHALL, without EDIV_RADIX4_EN, use radix-2 iteration per REQ-015/REQ-016; results identical in both builds.

Structure
REQ-025 SHALL take state enum, default widths, and iteration counts (radix-2 and radix-4) from shared package ediv_pkg.
REQ-026 SHALL implement one shift-compare-subtract stage as combinational sub-module ediv_step, instanced once (radix-2) or twice in cascade (radix-4).

Verification
REQ-027 SHALL cover: dividend 1000, divisor 7, start -> done 17 clocks later, quotient 142, remainder 6, dbz 0.
REQ-028 SHALL cover: dividend 0xFFFF, divisor 0xFF -> quotient 0x0101, remainder 0; dividend 5, divisor 9 -> quotient 0, remainder 5.
REQ-029 SHALL cover: dividend 0x1234, divisor 0 -> done 1 clock later, quotient 0xFFFF, remainder 0x34, dbz 1.
REQ-030 SHALL cover: start re-pulsed with new operands at cycles 3 and 17 of a 1000/7 run -> ignored, results 142/6, single done pulse.
REQ-031 SHALL cover: reset_n low at cycle 8 of a run -> outputs 0 immediately, no done; subsequent 200/3 -> quotient 66, remainder 2.
REQ-032 SHALL cover, with EDIV_RADIX4_EN: 1000/7 -> done 9 clocks after start, quotient 142, remainder 6.
